// File: rtl/clock_pkg.sv
// Shared FSM state encoding, BCD limits and the BCD increment helper
// used by the HH:MM clock generator.
package clock_pkg;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } clk_state_t;

  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HR_MAX   = 8'h23;
  localparam logic [5:0] SEC_LAST = 6'd59;

  // Wraps to 00 at lim, otherwise carries units 9 into the tens digit.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    logic [7:0] r;
    if (v == lim)
      r = '0;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Key debouncer with registered rising-edge press pulse.
// Accepts a new level after DB_CYCLES consecutive disagreeing samples.
module key_debounce #(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          level;
  logic          level_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
      if (key != level) begin
        if (cnt == CNT_LAST) begin
          level <= key;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/hhmm_clock_gen.sv
// HH:MM BCD clock with run/stop, minute and hour keys.
// Seconds and prescaler are internal and frozen while stopped.
module hhmm_clock_gen
  import clock_pkg::*;
#(
  parameter int unsigned SEC_DIV   = 50_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_run,
  input  logic       key_min,
  input  logic       key_hr,
  output logic [7:0] q,
  output logic [7:0] p,
  output logic       running,
  output logic       upd
);

  localparam int unsigned PW = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SEC_DIV - 1);

  logic run_ev;
  logic min_ev;
  logic hr_ev;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (.clk(clk), .rst(rst), .key(key_run), .press(run_ev));
  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_min (.clk(clk), .rst(rst), .key(key_min), .press(min_ev));
  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_hr  (.clk(clk), .rst(rst), .key(key_hr),  .press(hr_ev));

  clk_state_t    state;
  logic [PW-1:0] presc;
  logic [5:0]    sec;
  logic          chg;
  logic          sec_tick;
  logic          min_tick;
  logic          min_adv;
  logic          hr_carry;

  // A minute key event suppresses the hour carry even when it lands on min_tick.
  always_comb begin
    sec_tick = (state == RUN) && (presc == PRE_LAST);
    min_tick = sec_tick && (sec == SEC_LAST);
    min_adv  = min_ev | min_tick;
    hr_carry = min_tick && !min_ev && (q == MIN_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= STOP;
      running <= 1'b0;
      presc   <= '0;
      sec     <= '0;
      q       <= '0;
      p       <= '0;
      chg     <= 1'b0;
      upd     <= 1'b0;
    end else begin
      if (run_ev) begin
        state   <= (state == RUN) ? STOP : RUN;
        running <= (state == STOP);
      end

      if (min_ev) begin
        if (state == RUN) begin
          presc <= '0;
          sec   <= '0;
        end
      end else if (state == RUN) begin
        if (sec_tick) begin
          presc <= '0;
          sec   <= (sec == SEC_LAST) ? '0 : sec + 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end

      if (min_adv)
        q <= bcd_inc(q, MIN_MAX);

      case ({hr_carry, hr_ev})
        2'b11:         p <= bcd_inc(bcd_inc(p, HR_MAX), HR_MAX);
        2'b01, 2'b10:  p <= bcd_inc(p, HR_MAX);
        default:       ;
      endcase

      // upd trails the q/p update by one cycle
      chg <= min_adv | hr_carry | hr_ev;
      upd <= chg;
    end
  end

endmodule

// File: tb/tb_hhmm_clock_gen.sv
// Scoreboard bench for hhmm_clock_gen with SEC_DIV=4, DB_CYCLES=3.
// A time-based reference model predicts upd/running events; a monitor pops and compares.
module tb_hhmm_clock_gen;

  localparam int SD      = 4;
  localparam int DB      = 3;
  localparam int MIN_CYC = 60 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_run = 1'b0;
  logic       key_min = 1'b0;
  logic       key_hr  = 1'b0;
  logic [7:0] q;
  logic [7:0] p;
  logic       running;
  logic       upd;

  hhmm_clock_gen #(.SEC_DIV(SD), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .key_run(key_run), .key_min(key_min), .key_hr(key_hr),
    .q(q), .p(p), .running(running), .upd(upd)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct { int at; logic [7:0] q; logic [7:0] p; } upd_exp_t;
  typedef struct { int at; logic val; } run_exp_t;
  upd_exp_t upd_q[$];
  run_exp_t run_q[$];

  // Reference model: wall time in RUN cycles, minutes/hours as plain integers.
  int edge_no;
  int m_min, m_hr, run_cyc;
  bit m_run;
  bit lvl[3];
  int diff_len[3];
  int ev_at[3];
  int upd_seen = 0;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    edge_no = 0; m_min = 0; m_hr = 0; run_cyc = 0; m_run = 0;
    for (int k = 0; k < 3; k++) begin
      lvl[k] = 0; diff_len[k] = 0; ev_at[k] = -1;
    end
    upd_q.delete();
    run_q.delete();
  endtask

  task automatic model_step(input logic [2:0] raw);
    bit ev[3];
    bit adv_m, carry;
    int adv_h;
    edge_no++;
    for (int k = 0; k < 3; k++) begin
      ev[k] = (ev_at[k] == edge_no);
      if (ev[k]) ev_at[k] = -1;
    end
    adv_m = 0; carry = 0;
    if (ev[1]) begin
      adv_m = 1;
      if (m_run) run_cyc = 0;
    end else if (m_run) begin
      run_cyc++;
      if (run_cyc % MIN_CYC == 0) begin
        adv_m = 1;
        carry = (m_min == 59);
      end
    end
    adv_h = int'(carry) + int'(ev[2]);
    if (adv_m) m_min = (m_min + 1) % 60;
    m_hr = (m_hr + adv_h) % 24;
    if (adv_m || adv_h != 0)
      upd_q.push_back('{at: edge_no + 1, q: to_bcd(m_min), p: to_bcd(m_hr)});
    if (ev[0]) begin
      m_run = !m_run;
      run_q.push_back('{at: edge_no, val: m_run});
    end
    // a new key level is accepted after DB disagreeing samples; its press acts two edges later
    for (int k = 0; k < 3; k++) begin
      if (raw[k] != lvl[k]) begin
        diff_len[k]++;
        if (diff_len[k] == DB) begin
          lvl[k] = raw[k];
          diff_len[k] = 0;
          if (lvl[k]) ev_at[k] = edge_no + 2;
        end
      end else begin
        diff_len[k] = 0;
      end
    end
  endtask

  initial begin : model_proc
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step({key_hr, key_min, key_run});
    end
  end

  initial begin : monitor
    logic last_run;
    upd_exp_t ue;
    run_exp_t re;
    last_run = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last_run = 1'b0;
      end else begin
        while (upd_q.size() > 0 && upd_q[0].at < edge_no) begin
          ue = upd_q.pop_front(); total++; bad++;
          $display("FAIL upd_missing: no pulse at edge %0d, required q=%h p=%h", ue.at, ue.q, ue.p);
        end
        while (run_q.size() > 0 && run_q[0].at < edge_no) begin
          re = run_q.pop_front(); total++; bad++;
          $display("FAIL run_missing: no change at edge %0d, required running=%0b", re.at, re.val);
        end
        if (upd !== 1'b0) begin
          upd_seen++; total++;
          if (upd_q.size() == 0) begin
            bad++;
            $display("FAIL upd_unexpected: upd=%b at edge %0d q=%h p=%h, required no pulse", upd, edge_no, q, p);
          end else begin
            ue = upd_q.pop_front();
            if (upd !== 1'b1 || ue.at != edge_no || q !== ue.q || p !== ue.p) begin
              bad++;
              $display("FAIL upd_check: edge=%0d q=%h p=%h, required edge=%0d q=%h p=%h",
                       edge_no, q, p, ue.at, ue.q, ue.p);
            end
          end
        end
        if (running !== last_run) begin
          total++;
          if (run_q.size() == 0) begin
            bad++;
            $display("FAIL run_unexpected: running=%b at edge %0d, required %b", running, edge_no, last_run);
          end else begin
            re = run_q.pop_front();
            if (re.at != edge_no || running !== re.val) begin
              bad++;
              $display("FAIL run_check: edge=%0d running=%b, required edge=%0d running=%b",
                       edge_no, running, re.at, re.val);
            end
          end
          last_run = running;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [2:0] mask, input int unsigned hold, input int unsigned gap);
    {key_hr, key_min, key_run} = mask;
    tick(hold);
    {key_hr, key_min, key_run} = 3'b000;
    tick(gap);
  endtask

  task automatic preload(input int hr_t, input int min_t);
    logic [2:0] mask;
    for (int i = 0; i < 300 && (m_hr != hr_t || m_min != min_t); i++) begin
      mask = {m_hr != hr_t, m_min != min_t, 1'b0};
      if ($urandom_range(0, 4) == 0) press(mask, $urandom_range(1, 2), $urandom_range(3, 5));
      press(mask, $urandom_range(3, 6), $urandom_range(3, 6));
    end
  endtask

  initial begin : stimulus
    int base;
    bit found;

    rst = 1'b0;
    tick(3);
    check("reset_q", q, 8'h00);
    check("reset_p", p, 8'h00);
    check("reset_running", running, 1'b0);
    check("reset_upd", upd, 1'b0);
    rst = 1'b1;
    tick(1);
    check("first_cycle_upd", upd, 1'b0);

    press(3'b001, 2, 6);
    check("bounce_running", running, 1'b0);

    press(3'b001, 5, 4);
    check("run_on", running, 1'b1);
    base = upd_seen;
    tick(MIN_CYC + 4);
    check("one_minute_q", q, 8'h01);
    check("one_minute_p", p, 8'h00);
    check("one_minute_upd_count", 32'(upd_seen - base), 32'd1);
    press(3'b001, 4, 4);
    check("run_off", running, 1'b0);

    preload(23, 59);
    check("preload_q", q, 8'h59);
    check("preload_p", p, 8'h23);
    press(3'b001, 4, 4);
    for (int i = 0; i < 300 && (m_min != 0 || m_hr != 0); i++) tick(1);
    tick(3);
    check("midnight_q", q, 8'h00);
    check("midnight_p", p, 8'h00);

    press(3'b001, 4, 4);
    preload(22, 59);
    check("preload2_q", q, 8'h59);
    check("preload2_p", p, 8'h22);
    press(3'b001, 4, 4);
    found = 0;
    for (int i = 0; i < 600; i++) begin
      if (m_run && (run_cyc % MIN_CYC) == MIN_CYC - 5) begin
        found = 1;
        break;
      end
      tick(1);
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL align_timeout: minute boundary not reached, required within 600 cycles");
    end
    press(3'b100, 4, 4);
    check("coincide_p", p, 8'h00);
    check("coincide_q", q, 8'h00);

    for (int i = 0; i < 40; i++) begin
      press(3'($urandom_range(0, 7)), $urandom_range(1, 6), $urandom_range(1, 8));
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 250));
    end
    tick(10);

    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    preload(0, 37);
    press(3'b001, 4, 4);
    tick($urandom_range(1, 2));
    check("pre_reset_q", q, 8'h37);
    check("pre_reset_running", running, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_q", q, 8'h00);
    check("async_reset_p", p, 8'h00);
    check("async_reset_running", running, 1'b0);
    check("async_reset_upd", upd, 1'b0);

    key_min = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(5);
    key_min = 1'b0;
    tick(6);
    check("held_key_requalify_q", q, 8'h01);
    check("held_key_running", running, 1'b0);

    tick(20);
    check("upd_queue_drained", 32'(upd_q.size()), 32'd0);
    check("run_queue_drained", 32'(run_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
